// File: rtl/vision_pkg.sv
// Shared constants and state encoding for the HSV -> RGB back end.
package vision_pkg;

  localparam int HUE_SECTOR      = 60;
  localparam int SAT_MAX         = 100;
  localparam int HUE_WRAP        = 360;
  localparam int HSV2RGB_LATENCY = 50;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIV_H = 3'd1,
    ST_DIV_C = 3'd2,
    ST_DIV_X = 3'd3,
    ST_PACK  = 3'd4,
    ST_HOLD  = 3'd5
  } hsv_state_e;

endpackage

// File: rtl/seq_div16.sv
// Restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
module seq_div16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        done
);

  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  dsr_q, dsr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] src_quo;
  logic [7:0]  src_rem;
  logic [7:0]  src_dsr;
  logic [8:0]  shifted;
  logic [8:0]  diff;
  logic        fits;
  logic [15:0] step_quo;
  logic [7:0]  step_rem;

  // The first quotient bit is produced on the start edge itself, so the
  // last of the 16 bits lands 15 edges later.
  always_comb begin
    src_quo  = start ? dividend : quo_q;
    src_rem  = start ? 8'd0 : rem_q;
    src_dsr  = start ? divisor : dsr_q;
    shifted  = {src_rem, src_quo[15]};
    diff     = shifted - {1'b0, src_dsr};
    fits     = (shifted >= {1'b0, src_dsr});
    step_rem = fits ? diff[7:0] : shifted[7:0];
    step_quo = {src_quo[14:0], fits};
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      quo_d  = step_quo;
      rem_d  = step_rem;
      dsr_d  = divisor;
      cnt_d  = 4'd15;
      busy_d = 1'b1;
    end else if (busy_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/hsv_to_rgb.sv
// HSV (deg, %, 0-255) to 8-bit RGB, one pixel in flight, three divides on one divider.
// state    | meaning
// IDLE     | in_ready, waiting for a pixel
// DIV_H    | h / 60 -> sector, rem
// DIV_C    | (v*s) / 100 -> C
// DIV_X    | (C*k) / 60 -> X
// PACK     | sector map plus m into red/green/blue
// HOLD     | out_valid until out_ready
module hsv_to_rgb
  import vision_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] hue,
  input  logic [7:0] saturation,
  input  logic [7:0] value,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [8:0] HUE_WRAP_9 = 9'(HUE_WRAP);
  localparam logic [7:0] SAT_MAX_8  = 8'(SAT_MAX);
  localparam logic [7:0] SECTOR_8   = 8'(HUE_SECTOR);
  localparam logic [5:0] SECTOR_6   = 6'(HUE_SECTOR);

  hsv_state_e state_q, state_d;
  logic       alive_q;
  logic       kick_q, kick_d;
  logic [8:0] h_q, h_d;
  logic [7:0] s_q, s_d;
  logic [7:0] v_q, v_d;
  logic [2:0] sector_q, sector_d;
  logic [5:0] hrem_q, hrem_d;
  logic [7:0] c_q, c_d;
  logic [7:0] x_q, x_d;
  logic [7:0] red_q, red_d;
  logic [7:0] green_q, green_d;
  logic [7:0] blue_q, blue_d;

  logic        div_start;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic [15:0] div_quo;
  logic [7:0]  div_rem;
  logic        div_done;

  logic [15:0] prod_vs;
  logic [15:0] prod_ck;
  logic [5:0]  k;
  logic [7:0]  m;
  logic [7:0]  pr, pg, pb;

  seq_div16 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // C*k uses the quotient straight off the divider so the X divide can
  // start on the same edge that C is captured.
  assign k       = sector_q[0] ? (SECTOR_6 - hrem_q) : hrem_q;
  assign prod_vs = {8'd0, v_q} * {8'd0, s_q};
  assign prod_ck = {8'd0, 8'(div_quo)} * {10'd0, k};

  assign in_ready  = alive_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;

  always_comb begin
    m  = v_q - c_q;
    pr = 8'd0;
    pg = 8'd0;
    pb = 8'd0;
    case (sector_q)
      3'd0: begin pr = c_q; pg = x_q; end
      3'd1: begin pr = x_q; pg = c_q; end
      3'd2: begin pg = c_q; pb = x_q; end
      3'd3: begin pg = x_q; pb = c_q; end
      3'd4: begin pr = x_q; pb = c_q; end
      3'd5: begin pr = c_q; pb = x_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    kick_d       = 1'b0;
    h_d          = h_q;
    s_d          = s_q;
    v_d          = v_q;
    sector_d     = sector_q;
    hrem_d       = hrem_q;
    c_d          = c_q;
    x_d          = x_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    div_start    = 1'b0;
    div_dividend = {7'd0, h_q};
    div_divisor  = SECTOR_8;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          h_d     = (hue >= HUE_WRAP_9) ? (hue - HUE_WRAP_9) : hue;
          s_d     = (saturation > SAT_MAX_8) ? SAT_MAX_8 : saturation;
          v_d     = value;
          kick_d  = 1'b1;
          state_d = ST_DIV_H;
        end
      end
      ST_DIV_H: begin
        div_start = kick_q;
        if (div_done) begin
          sector_d     = 3'(div_quo);
          hrem_d       = 6'(div_rem);
          div_start    = 1'b1;
          div_dividend = prod_vs;
          div_divisor  = SAT_MAX_8;
          state_d      = ST_DIV_C;
        end
      end
      ST_DIV_C: begin
        if (div_done) begin
          c_d          = 8'(div_quo);
          div_start    = 1'b1;
          div_dividend = prod_ck;
          div_divisor  = SECTOR_8;
          state_d      = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        if (div_done) begin
          x_d     = 8'(div_quo);
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        red_d   = pr + m;
        green_d = pg + m;
        blue_d  = pb + m;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      alive_q  <= 1'b0;
      kick_q   <= 1'b0;
      h_q      <= '0;
      s_q      <= '0;
      v_q      <= '0;
      sector_q <= '0;
      hrem_q   <= '0;
      c_q      <= '0;
      x_q      <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      kick_q   <= kick_d;
      h_q      <= h_d;
      s_q      <= s_d;
      v_q      <= v_d;
      sector_q <= sector_d;
      hrem_q   <= hrem_d;
      c_q      <= c_d;
      x_q      <= x_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: driver pushes expected RGB, monitor pops on out_valid.
module tb_hsv_to_rgb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] hue = '0;
  logic [7:0] saturation = '0;
  logic [7:0] value = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] red, green, blue;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         acc;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  hsv_to_rgb dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hue        (hue),
    .saturation (saturation),
    .value      (value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .red        (red),
    .green      (green),
    .blue       (blue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: first cycle of out_valid pops and compares; later cycles check hold stability.
  logic       ov_prev = 1'b0;
  logic [7:0] hr, hg, hb;
  exp_t       e;
  always @(negedge clk) begin
    if (!rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("red", {24'd0, red}, {24'd0, e.r});
          check("green", {24'd0, green}, {24'd0, e.g});
          check("blue", {24'd0, blue}, {24'd0, e.b});
          check("latency", cyc - e.acc, 50);
        end
        hr = red;
        hg = green;
        hb = blue;
      end else if (out_valid) begin
        check("hold_red", {24'd0, red}, {24'd0, hr});
        check("hold_green", {24'd0, green}, {24'd0, hg});
        check("hold_blue", {24'd0, blue}, {24'd0, hb});
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input bit want);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    hue        = h;
    saturation = s;
    value      = v;
    in_valid   = 1'b1;
    if (want) sb.push_back('{r: r, g: g, b: b, acc: cyc + 1});
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    hue        = ~h;
    saturation = ~s;
    value      = ~v;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vecs = '{
      '{9'd0,   8'd100, 8'd255, 8'd255, 8'd0,   8'd0},
      '{9'd120, 8'd100, 8'd255, 8'd0,   8'd255, 8'd0},
      '{9'd240, 8'd100, 8'd255, 8'd0,   8'd0,   8'd255},
      '{9'd30,  8'd100, 8'd200, 8'd200, 8'd100, 8'd0},
      '{9'd300, 8'd50,  8'd200, 8'd200, 8'd100, 8'd200},
      '{9'd200, 8'd0,   8'd128, 8'd128, 8'd128, 8'd128},
      '{9'd90,  8'd150, 8'd255, 8'd127, 8'd255, 8'd0},
      '{9'd90,  8'd100, 8'd255, 8'd127, 8'd255, 8'd0},
      '{9'd420, 8'd100, 8'd255, 8'd255, 8'd255, 8'd0},
      '{9'd60,  8'd100, 8'd255, 8'd255, 8'd255, 8'd0},
      '{9'd359, 8'd100, 8'd255, 8'd255, 8'd0,   8'd4},
      '{9'd511, 8'd100, 8'd255, 8'd0,   8'd255, 8'd131},
      '{9'd45,  8'd100, 8'd0,   8'd0,   8'd0,   8'd0},
      '{9'd180, 8'd40,  8'd250, 8'd150, 8'd250, 8'd250},
      '{9'd200, 8'd75,  8'd240, 8'd60,  8'd180, 8'd240},
      '{9'd250, 8'd60,  8'd100, 8'd50,  8'd40,  8'd100}
    };

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rgb", {8'd0, red, green, blue}, 32'd0);
    rst = 1'b1;
    #1 check("release_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("release_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i])
      send(vecs[i].h, vecs[i].s, vecs[i].v, vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
    drain();

    // Backpressure: result held for 10 cycles with ignored in_valid pulses.
    out_ready = 1'b0;
    send(9'd30, 8'd100, 8'd200, 8'd200, 8'd100, 8'd0, 1'b1);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid   = (i % 2 == 0);
      hue        = 9'd0;
      saturation = 8'd100;
      value      = 8'd255;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (60) @(negedge clk);
    check("bp_no_ghost_pixel", {31'd0, in_ready}, 32'd1);

    // Reset mid-operation: in-flight pixel is dropped.
    send(9'd120, 8'd100, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (19) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_rgb", {8'd0, red, green, blue}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (70) @(negedge clk);
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);
    send(9'd0, 8'd100, 8'd255, 8'd255, 8'd0, 8'd0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
